// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Optional feature macro: SEVSEG_DIMMING_EN (adds PWM brightness control).
package sevseg_pkg;

    typedef logic [2:0] digit_idx_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GUARD,
        S_ON
    } scan_state_e;

    // All segments off (active-low pins)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex glyphs, {a,b,c,d,e,f,g} in [6:0], active-low
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, // 0
        7'b1001111, // 1
        7'b0010010, // 2
        7'b0000110, // 3
        7'b1001100, // 4
        7'b0100100, // 5
        7'b0100000, // 6
        7'b0001111, // 7
        7'b0000000, // 8
        7'b0000100, // 9
        7'b0001000, // A
        7'b1100000, // b
        7'b0110001, // C
        7'b1000010, // d
        7'b0110000, // E
        7'b0111000  // F
    };

endpackage

// File: rtl/sevseg_scan_driver_decode.sv
// Combinational hex nibble to seven-segment glyph lookup.
module sevseg_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_c
);

    assign seg_c = SEG_TABLE[nib];

endmodule

// File: rtl/sevseg_scan_driver.sv
// Eight-digit time-multiplexed seven-segment scan driver with snapshot,
// guard interval, leading-zero blanking, decimal points and frame strobe.
// Optional feature macro: SEVSEG_DIMMING_EN (brightness PWM within S_ON).
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned GUARD   = 4
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [31:0] disp_val,
    input  logic        disp_load,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
`ifdef SEVSEG_DIMMING_EN
    input  logic [3:0]  brightness,
`endif
    output logic [7:0]  an,
    output logic [6:0]  sev_out,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned   PW      = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST    = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GUARD_P = PW'(GUARD);

    scan_state_e   state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q, idx_d;
    logic [31:0]   snap_q, snap_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    sev_q, sev_d;
    logic          dp_q, dp_d;
    logic          tick_q, tick_d;
    logic          slot_start;
    logic [3:0]    nib;
    logic [6:0]    seg_c;
    logic [31:0]   upper;
    logic          lz_blank;
`ifdef SEVSEG_DIMMING_EN
    logic [3:0]    bright_q, bright_d;
`endif

    // Slot sequencing: prescaler, digit index, guard/on phase and frame strobe
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        idx_d      = idx_q;
        slot_start = 1'b0;
        tick_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d    = S_GUARD;
                slot_start = 1'b1;
            end
            default: begin
                if (presc_q == LAST) begin
                    presc_d    = '0;
                    idx_d      = idx_q + 3'd1;
                    state_d    = S_GUARD;
                    slot_start = 1'b1;
                    tick_d     = (idx_q == 3'd7);
                end else begin
                    presc_d = presc_q + PW'(1);
                    state_d = (presc_d >= GUARD_P) ? S_ON : S_GUARD;
                end
            end
        endcase
    end

    // Nibble and blanking for the digit of the slot being entered
    assign nib      = snap_q[{idx_d, 2'b00} +: 4];
    assign upper    = snap_q >> {idx_d, 2'b00};
    assign lz_blank = blank_lz && (idx_d != 3'd0) && (upper == 32'd0);

    sevseg_decode u_decode (
        .nib   (nib),
        .seg_c (seg_c)
    );

    // Snapshot capture, slot-start glyph latch and anode drive
    always_comb begin
        snap_d = disp_load ? disp_val : snap_q;
        sev_d  = sev_q;
        dp_d   = dp_q;
`ifdef SEVSEG_DIMMING_EN
        bright_d = bright_q;
`endif
        if (slot_start) begin
            sev_d = lz_blank ? SEG_BLANK : seg_c;
            dp_d  = ~dp_mask[idx_d];
`ifdef SEVSEG_DIMMING_EN
            bright_d = brightness;
`endif
        end
        an_d = 8'hFF;
        if (state_d == S_ON) begin
`ifdef SEVSEG_DIMMING_EN
            if (presc_d[3:0] < bright_q) begin
                an_d = ~(8'h01 << idx_d);
            end
`else
            an_d = ~(8'h01 << idx_d);
`endif
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            idx_q    <= '0;
            snap_q   <= '0;
            an_q     <= 8'hFF;
            sev_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
`ifdef SEVSEG_DIMMING_EN
            bright_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            snap_q   <= snap_d;
            an_q     <= an_d;
            sev_q    <= sev_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
`ifdef SEVSEG_DIMMING_EN
            bright_q <= bright_d;
`endif
        end
    end

    assign an         = an_q;
    assign sev_out    = sev_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Self-checking bench for sevseg_scan_driver; pins are predicted from the
// cycle count since scan start (slot = t / CLK_DIV, phase = t % CLK_DIV).
module tb_sevseg_scan_driver;

    localparam int CLK_DIV = 32;
    localparam int GUARD   = 4;
    localparam int FRAME   = 8 * CLK_DIV;

    logic        clk = 1'b0;
    logic        Rst;
    logic [31:0] disp_val;
    logic        disp_load;
    logic        blank_lz;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  sev_out;
    logic        dp;
    logic        frame_tick;
`ifdef SEVSEG_DIMMING_EN
    logic [3:0]  brightness;
    logic [3:0]  m_bright;
`endif

    int          checks = 0;
    int          errors = 0;
    int          t;          // cycles since leaving idle, -1 while idle/reset
    logic [31:0] m_snap;     // model of the snapshot register
    logic [31:0] s_val;      // snapshot as seen at current slot start
    logic [7:0]  s_dp;
    logic        s_blz;

    logic [6:0] hex_seg [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    sevseg_scan_driver #(
        .CLK_DIV (CLK_DIV),
        .GUARD   (GUARD)
    ) dut (
        .clk        (clk),
        .Rst        (Rst),
        .disp_val   (disp_val),
        .disp_load  (disp_load),
        .blank_lz   (blank_lz),
        .dp_mask    (dp_mask),
`ifdef SEVSEG_DIMMING_EN
        .brightness (brightness),
`endif
        .an         (an),
        .sev_out    (sev_out),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Predict all pins from t and the values latched at slot start
    task automatic check_pins();
        int         idx, p;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_tick;
        logic [3:0] d;
        if (t < 0) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
        end else begin
            idx  = (t / CLK_DIV) % 8;
            p    = t % CLK_DIV;
            e_an = 8'hFF;
            if (p >= GUARD) e_an = ~(8'h01 << idx);
`ifdef SEVSEG_DIMMING_EN
            if ((p % 16) >= int'(m_bright)) e_an = 8'hFF;
`endif
            d     = 4'((s_val >> (4 * idx)) & 32'hF);
            e_seg = hex_seg[d];
            if (s_blz && idx != 0 && (s_val >> (4 * idx)) == 32'd0) e_seg = 7'h7F;
            e_dp   = ~s_dp[idx];
            e_tick = (t > 0) && (t % FRAME == 0);
        end
        chk("an", 32'(an), 32'(e_an));
        chk("sev_out", 32'(sev_out), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("frame_tick", 32'(frame_tick), 32'(e_tick));
    endtask

    // One clock: update the model at the edge, then check on the falling edge
    task automatic tick();
        @(posedge clk);
        if (Rst) begin
            t = -1;
            m_snap = 32'd0;
        end else begin
            if (t < 0 || ((t + 1) % CLK_DIV) == 0) begin
                s_val = m_snap;
                s_dp  = dp_mask;
                s_blz = blank_lz;
`ifdef SEVSEG_DIMMING_EN
                m_bright = brightness;
`endif
            end
            if (disp_load) m_snap = disp_val;
            t++;
        end
        @(negedge clk);
        check_pins();
    endtask

    task automatic run_to(input int target);
        int n;
        n = target - t;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [31:0] rand_word();
        int unsigned sh;
        sh = $urandom_range(0, 8);
        return (sh == 8) ? 32'd0 : ($urandom >> (4 * sh));
    endfunction

    initial begin
        int base;
        int lit;
        Rst = 1'b1; disp_val = '0; disp_load = 1'b0; blank_lz = 1'b0; dp_mask = '0;
`ifdef SEVSEG_DIMMING_EN
        brightness = 4'd15; m_bright = 4'd0;
`endif
        t = -1; m_snap = '0; s_val = '0; s_dp = '0; s_blz = 1'b0;

        // Reset state
        tick(); tick();

        // Load 89ABCDEF on the idle-exit edge; slot 0 of frame 1 still shows 0
        Rst = 1'b0; disp_val = 32'h89AB_CDEF; disp_load = 1'b1;
        tick();
        disp_load = 1'b0;
        run_to(FRAME + GUARD - 1);
        chk("frame2_slot0_guard_an", 32'(an), 32'h0000_00FF);
        tick();
        chk("frame2_slot0_an", 32'(an), 32'h0000_00FE);
        chk("frame2_slot0_seg", 32'(sev_out), 32'h0000_0038);
        run_to(FRAME + 7 * CLK_DIV + GUARD);
        chk("frame2_slot7_an", 32'(an), 32'h0000_007F);
        chk("frame2_slot7_seg", 32'(sev_out), 32'h0000_0000);
        run_to(2 * FRAME);
        chk("frame_tick_wrap", 32'(frame_tick), 32'h1);

        // Leading-zero blanking and decimal points
        disp_val = 32'h0000_0050; disp_load = 1'b1; blank_lz = 1'b1; dp_mask = 8'h81;
        tick();
        disp_load = 1'b0;
        base = (t / FRAME + 1) * FRAME;
        run_to(base + GUARD);
        chk("blz_d0_seg", 32'(sev_out), 32'h01);
        chk("blz_d0_dp", 32'(dp), 32'h0);
        run_to(base + CLK_DIV + GUARD);
        chk("blz_d1_seg", 32'(sev_out), 32'h24);
        chk("blz_d1_dp", 32'(dp), 32'h1);
        run_to(base + 2 * CLK_DIV + GUARD);
        chk("blz_d2_seg", 32'(sev_out), 32'h7F);
        run_to(base + 7 * CLK_DIV + GUARD);
        chk("blz_d7_seg", 32'(sev_out), 32'h7F);
        chk("blz_d7_dp", 32'(dp), 32'h0);
        run_to(base + FRAME + 1);

        // Load coinciding with a slot boundary
        blank_lz = 1'b0;
        while (t % CLK_DIV != CLK_DIV - 1) tick();
        disp_val = 32'h1234_5678; disp_load = 1'b1;
        tick();
        disp_load = 1'b0;
        run_to(t + 2 * CLK_DIV);

        // Randomized traffic over several frames
        for (int i = 0; i < 6 * FRAME; i++) begin
            disp_load = ($urandom_range(0, 15) == 0);
            disp_val  = rand_word();
            if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 15) == 0) dp_mask = 8'($urandom);
`ifdef SEVSEG_DIMMING_EN
            if ($urandom_range(0, 15) == 0) brightness = 4'($urandom);
`endif
            tick();
        end
        disp_load = 1'b0;

        // Asynchronous reset in the middle of a slot
        while (t % CLK_DIV != 17) tick();
        #2 Rst = 1'b1;
        #1;
        chk("async_rst_an", 32'(an), 32'h0000_00FF);
        chk("async_rst_seg", 32'(sev_out), 32'h0000_007F);
        chk("async_rst_dp", 32'(dp), 32'h1);
        tick();
        Rst = 1'b0; blank_lz = 1'b0;
        run_to(GUARD);
        chk("resume_idx0_an", 32'(an), 32'h0000_00FE);
        chk("resume_idx0_seg", 32'(sev_out), 32'h0000_0001);
        run_to(FRAME + 1);

`ifdef SEVSEG_DIMMING_EN
        // Brightness 4 for one frame, then brightness 0 keeps every digit dark
        brightness = 4'd4;
        run_to(2 * FRAME + 1);
        brightness = 4'd0;
        run_to(3 * FRAME);
        lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (an !== 8'hFF) lit++;
        end
        chk("dim0_dark_cycles", 32'(lit), 32'd0);
`else
        lit = 0;
        run_to(2 * FRAME + 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
